// File: rtl/prio_irq_ctrl.sv
// Sequential 8-line interrupt controller with 74148-style active-low pins and cascade outputs.
// Define PRIO_ROTATE_EN for rotating priority; the default build uses fixed priority (7 highest).
module prio_irq_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       EI_bar,
   input  logic [7:0] A_bar,
   input  logic       mask_we,
   input  logic [7:0] mask_in,
   input  logic       ack,
   output logic       irq,
   output logic [2:0] Y_bar,
   output logic       GS_bar,
   output logic       EO_bar
);

   typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

   state_e     state_q, state_d;
   logic [7:0] pending_q, pending_d;
   logic [7:0] mask_q;
   logic [7:0] a_hist_q;
   logic [7:0] eligible;
   logic [7:0] fall;
   logic [7:0] clr;
   logic [2:0] idx_q, idx_d;
   logic [2:0] sel;
   logic       sel_vld;
   logic [2:0] y_bar_q;
   logic       gs_q, eo_q;
   logic [2:0] ptr;

`ifdef PRIO_ROTATE_EN
   logic [2:0] ptr_q, ptr_d;
   assign ptr = ptr_q;
`else
   assign ptr = 3'd7;
`endif

   assign fall      = a_hist_q & ~A_bar;
   assign eligible  = pending_q & ~mask_q;
   // A new falling edge in the ack cycle wins over the clear.
   assign pending_d = (pending_q & ~clr) | fall;

   // Walk from lowest to highest priority so the highest-priority hit is written last.
   always_comb begin
      logic [2:0] cand;
      cand    = '0;
      sel     = '0;
      sel_vld = 1'b0;
      for (int k = 7; k >= 0; k--) begin
         cand = ptr - 3'(k);
         if (eligible[cand]) begin
            sel     = cand;
            sel_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      clr     = '0;
`ifdef PRIO_ROTATE_EN
      ptr_d   = ptr_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (!EI_bar && sel_vld) begin
               idx_d   = sel;
               state_d = StGrant;
            end
         end
         StGrant: begin
            if (ack) begin
               clr[idx_q] = 1'b1;
               state_d    = StRelease;
`ifdef PRIO_ROTATE_EN
               ptr_d      = idx_q - 3'd1;
`endif
            end
         end
         StRelease: begin
            if (!ack) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         pending_q <= '0;
         mask_q    <= '0;
         a_hist_q  <= 8'hFF;
         idx_q     <= '0;
         y_bar_q   <= 3'b111;
         gs_q      <= 1'b1;
         eo_q      <= 1'b1;
`ifdef PRIO_ROTATE_EN
         ptr_q     <= 3'd7;
`endif
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         a_hist_q  <= A_bar;
         idx_q     <= idx_d;
         gs_q      <= ~(~EI_bar & |eligible);
         eo_q      <= ~(~EI_bar & ~|eligible);
         if (mask_we) mask_q <= mask_in;
         if (state_q == StIdle && state_d == StGrant) y_bar_q <= ~sel;
`ifdef PRIO_ROTATE_EN
         ptr_q     <= ptr_d;
`endif
      end
   end

   assign irq    = (state_q == StGrant);
   assign Y_bar  = y_bar_q;
   assign GS_bar = gs_q;
   assign EO_bar = eo_q;

endmodule
